reg_file_dump_reader: RTL
=========================

// Module: reg_file_dump_reader
// PURPOSE
//  Read-side sequencer for the 16x32 register file: walks a range of register
//  addresses on one RF read port and streams the contents out on a valid/ready
//  interface. Used for debug dumps and for bench self-checking of
//  REGISTER_FILE_MODULE contents after a write sequence.
//  Sits between a register-file read port (RN or RM) and a debug/trace consumer.
// PARAMETERS
//  DATA_W      32  width of a register word
//  ADDR_W      4   register address width; NUM_REGS = 2**ADDR_W
//  RD_LATENCY  0   RF read latency in cycles; legal values 0 (comb) or 1 (registered)
// PORTS
//  CLK        in   1       clock; all state changes on rising edge
//  RST        in   1       synchronous, active-high reset
//  START      in   1       begin a dump; sampled only in IDLE
//  ABORT      in   1       cancel the dump in progress; no effect in IDLE
//  FIRST_ADDR in   ADDR_W  first register index, sampled with START
//  LAST_ADDR  in   ADDR_W  last register index, sampled with START
//  RF_ADDRS   out  ADDR_W  address driven to the RF read port
//  RF_DATA    in   DATA_W  RF read data for RF_ADDRS
//  OUT_VALID  out  1       OUT_* hold a valid word
//  OUT_READY  in   1       consumer accepts word when OUT_VALID && OUT_READY
//  OUT_DATA   out  DATA_W  register contents
//  OUT_INDEX  out  ADDR_W  register index of OUT_DATA
//  OUT_LAST   out  1       word is the final one of the dump
//  BUSY       out  1       high in any state except IDLE
//  DONE       out  1       one-cycle pulse after final handshake
// BEHAVIOUR
//  - Reset: RF_ADDRS=0, OUT_VALID=0, OUT_DATA=0, OUT_INDEX=0, OUT_LAST=0,
//    BUSY=0, DONE=0, state IDLE. RST mid-dump: all of the above at next edge;
//    dump is lost, no DONE.
//  - States: IDLE, FETCH, WAIT (only when RD_LATENCY=1), SEND.
//  - IDLE: START=1 -> latch cur=FIRST_ADDR, last=LAST_ADDR; -> FETCH.
//  - FETCH: RF_ADDRS=cur. RD_LATENCY=0: capture RF_DATA into OUT_DATA,
//    OUT_INDEX=cur, OUT_LAST=(cur==last); -> SEND. RD_LATENCY=1: -> WAIT, which
//    performs the capture and -> SEND.
//  - SEND: OUT_VALID=1. While !OUT_READY: OUT_DATA/INDEX/LAST and RF_ADDRS stable.
//    On handshake: if cur==last -> IDLE, DONE=1 for one cycle, BUSY=0 that cycle;
//    else cur=cur+1 (mod NUM_REGS) -> FETCH, OUT_VALID=0.
//  - Latency (RD_LATENCY=0): START high in cycle n -> RF_ADDRS=FIRST in n+1,
//    OUT_VALID=1 in n+2. RD_LATENCY=1 adds one cycle. Steady state: one word
//    per 2 (or 3) cycles with OUT_READY held high.
//  - Range: word count = ((LAST-FIRST) mod NUM_REGS)+1; LAST<FIRST wraps through
//    NUM_REGS-1 -> 0. FIRST==LAST: exactly one word, OUT_LAST=1.
//  - START while BUSY: ignored. START and ABORT together in IDLE: START wins.
//  - ABORT while BUSY: -> IDLE next edge, OUT_VALID=0, OUT_LAST=0, no DONE;
//    OUT_DATA/OUT_INDEX keep last values. ABORT in same cycle as final handshake:
//    handshake counts, ABORT ignored, DONE pulses.
//  - RF_ADDRS holds its last value in IDLE (RF read port is don't-care there).
//  - OUT_VALID never drops without a handshake except on ABORT or RST.
// TESTING
//  1. Write r[i]=i, i=0..15; START FIRST=0 LAST=15, READY=1 -> 16 words DATA=INDEX
//     =0..15, OUT_LAST only on 15, DONE once in cycle after last handshake.
//  2. START FIRST=14 LAST=1 -> INDEX sequence 14,15,0,1; OUT_LAST on 1; 4 words.
//  3. READY low 5 cycles while word 3 valid -> OUT_DATA=3, RF_ADDRS=3 stable 5
//     cycles; no word lost or duplicated; total 16 words.
//  4. ABORT while word 7 in SEND -> OUT_VALID=0, BUSY=0 next cycle, DONE never;
//     new START FIRST=2 LAST=2 -> single word DATA=2, OUT_LAST=1, DONE.
//  5. RST high during SEND of word 5 -> all outputs at reset values next cycle;
//     START pulses while BUSY are ignored (word count unchanged).
//  6. RD_LATENCY=1 build, repeat test 1 -> same data, OUT_VALID first at n+3.

Source files
------------

// File: rtl/reg_file_dump_reader.sv
// Read-side sequencer that walks a register-file address range on one read
// port and streams each word out on a valid/ready interface with index and last flag.
module reg_file_dump_reader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int RD_LATENCY = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [ADDR_W-1:0] FIRST_ADDR,
    input  logic [ADDR_W-1:0] LAST_ADDR,
    output logic [ADDR_W-1:0] RF_ADDRS,
    input  logic [DATA_W-1:0] RF_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [ADDR_W-1:0] OUT_INDEX,
    output logic              OUT_LAST,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              handshake;
    logic              at_last;

    assign handshake = (state_q == S_SEND) && OUT_READY;
    assign at_last   = (cur_q == last_q);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // START outranks ABORT here; ABORT has nothing to cancel in IDLE.
                if (START) begin
                    cur_d   = FIRST_ADDR;
                    last_d  = LAST_ADDR;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ABORT) begin
                    state_d    = S_IDLE;
                    out_last_d = 1'b0;
                end else if (RD_LATENCY == 0) begin
                    out_data_d  = RF_DATA;
                    out_index_d = cur_q;
                    out_last_d  = at_last;
                    state_d     = S_SEND;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ABORT) begin
                    state_d    = S_IDLE;
                    out_last_d = 1'b0;
                end else begin
                    out_data_d  = RF_DATA;
                    out_index_d = cur_q;
                    out_last_d  = at_last;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                // A final handshake completes the dump even if ABORT arrives with it.
                if (handshake && at_last) begin
                    state_d    = S_IDLE;
                    out_last_d = 1'b0;
                    done_d     = 1'b1;
                end else if (ABORT) begin
                    state_d    = S_IDLE;
                    out_last_d = 1'b0;
                end else if (handshake) begin
                    cur_d   = cur_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // The read address is the current cursor; it parks on its last value in IDLE.
    assign RF_ADDRS  = cur_q;
    assign OUT_VALID = (state_q == S_SEND);
    assign OUT_DATA  = out_data_q;
    assign OUT_INDEX = out_index_q;
    assign OUT_LAST  = out_last_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;

endmodule
